// File: rtl/cnn_dec_pkg.sv
// Shared decision-stage types and FP16 ordering helpers (score/index pair, -Inf, NaN detect, sort key).
// Latency: n/a (types and pure combinational functions only).
// Backpressure: n/a.
package cnn_dec_pkg;

  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

  // Index field is sized for the largest class count any decision block uses;
  // each block slices off the low bits it needs.
  localparam int unsigned SI_IDX_W = 8;

  typedef struct packed {
    logic [15:0]         val;
    logic [SI_IDX_W-1:0] idx;
  } score_idx_t;

  function automatic logic fp16_is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
  endfunction

  // Monotonic unsigned key: NaN collapses to -Inf, negatives invert fully,
  // positives flip only the sign bit, so -0 sorts just below +0.
  function automatic logic [15:0] fp16_key(input logic [15:0] v);
    logic [15:0] s;
    s = fp16_is_nan(v) ? FP16_NEG_INF : v;
    return s[15] ? ~s : {~s[15], s[14:0]};
  endfunction

endpackage

// File: rtl/topk_stream_dec_if.sv
// Score-in / top-K-out handshake bundle for topk_stream_dec (TOPK_NAN_COUNT_EN adds m_nan_cnt).
// Latency: n/a (wiring only).
// Backpressure: s_valid/s_ready on the input beat, m_valid/m_ready on the result.
interface topk_stream_dec_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CLASSES  = 10,
  parameter int K          = 3
);
  localparam int IDX_W = $clog2(N_CLASSES);

  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_WIDTH-1:0]   s_data;
  logic                    s_last;
  logic                    m_valid;
  logic                    m_ready;
  logic [K*DATA_WIDTH-1:0] m_val;   // entry 0 (best) in the low bits
  logic [K*IDX_W-1:0]      m_idx;
  logic                    m_err;
`ifdef TOPK_NAN_COUNT_EN
  localparam int NC_W = $clog2(N_CLASSES+1);
  logic [NC_W-1:0]         m_nan_cnt;
`endif

  // Producer of scores / consumer of results.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_val, m_idx, m_err
`ifdef TOPK_NAN_COUNT_EN
    , input m_nan_cnt
`endif
  );

  // The decision block itself.
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_val, m_idx, m_err
`ifdef TOPK_NAN_COUNT_EN
    , output m_nan_cnt
`endif
  );
endinterface

// File: rtl/topk_stream_dec_insert.sv
// Combinational K-way compare and shift-insert of one score into a descending top-K list.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the result is registered.
module topk_insert
  import cnn_dec_pkg::*;
#(
  parameter int K = 3
) (
  input  score_idx_t [K-1:0] cur_list,
  input  score_idx_t         new_ent,
  output score_idx_t [K-1:0] nxt_list
);

  // lt is monotonic down a sorted list, so the first set bit is the insert slot.
  // Strict compare keeps earlier equal scores above the new beat.
  logic [K-1:0] lt;

  for (genvar i = 0; i < K; i++) begin : g_slot
    assign lt[i] = fp16_key(cur_list[i].val) < fp16_key(new_ent.val);
    if (i == 0) begin : g_head
      assign nxt_list[i] = lt[i] ? new_ent : cur_list[i];
    end else begin : g_tail
      assign nxt_list[i] = !lt[i]    ? cur_list[i]   :
                           lt[i-1]   ? cur_list[i-1] : new_ent;
    end
  end

endmodule

// File: rtl/topk_stream_dec.sv
// Streaming top-K decision: folds one FP16 score per beat into a sorted list, reports K best per frame.
// Latency: result valid one cycle after the last accepted beat; optional TOPK_NAN_COUNT_EN adds m_nan_cnt.
// Backpressure: s_ready drops while a result waits; result held stable until m_ready.
module topk_stream_dec
  import cnn_dec_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_CLASSES  = 10,
  parameter int K          = 3
) (
  input logic              clk,
  input logic              rst,
  topk_stream_dec_if.slave bus
);
  localparam int IDX_W = $clog2(N_CLASSES);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(N_CLASSES-1);
  localparam score_idx_t EMPTY_ENT = {FP16_NEG_INF, {SI_IDX_W{1'b0}}};
  localparam score_idx_t [K-1:0] LIST_INIT = {K{EMPTY_ENT}};

  typedef enum logic {ST_ACCUM = 1'b0, ST_OUT = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  score_idx_t [K-1:0] list_q, list_d, out_q, out_d, ins_list;
  logic               err_q, err_d;
  score_idx_t         new_ent;
  logic               beat_acc;
`ifdef TOPK_NAN_COUNT_EN
  localparam int NC_W = $clog2(N_CLASSES+1);
  logic [NC_W-1:0]    nan_q, nan_d, out_nan_q, out_nan_d;
`endif

  assign new_ent.val = bus.s_data;
  assign new_ent.idx = SI_IDX_W'(cnt_q);

  topk_insert #(.K(K)) u_insert (
    .cur_list (list_q),
    .new_ent  (new_ent),
    .nxt_list (ins_list)
  );

  // Next-state: accumulate beats, latch the result at frame end, reinit on handoff.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    list_d   = list_q;
    out_d    = out_q;
    err_d    = err_q;
    beat_acc = bus.s_valid && (state_q == ST_ACCUM);
`ifdef TOPK_NAN_COUNT_EN
    nan_d     = nan_q;
    out_nan_d = out_nan_q;
`endif
    case (state_q)
      ST_ACCUM: begin
        if (beat_acc) begin
          list_d = ins_list;
          cnt_d  = (cnt_q == LAST_BEAT) ? cnt_q : cnt_q + 1'b1;
`ifdef TOPK_NAN_COUNT_EN
          nan_d  = nan_q + NC_W'(fp16_is_nan(bus.s_data));
`endif
          // A full-length frame without s_last is closed here and flagged.
          if (bus.s_last || (cnt_q == LAST_BEAT)) begin
            out_d   = ins_list;
            err_d   = (cnt_q != LAST_BEAT) || !bus.s_last;
            state_d = ST_OUT;
`ifdef TOPK_NAN_COUNT_EN
            out_nan_d = nan_d;
`endif
          end
        end
      end
      ST_OUT: begin
        if (bus.m_ready) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
          list_d  = LIST_INIT;
`ifdef TOPK_NAN_COUNT_EN
          nan_d   = '0;
`endif
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State and result registers, synchronous reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      cnt_q   <= '0;
      list_q  <= LIST_INIT;
      out_q   <= LIST_INIT;
      err_q   <= 1'b0;
`ifdef TOPK_NAN_COUNT_EN
      nan_q     <= '0;
      out_nan_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      list_q  <= list_d;
      out_q   <= out_d;
      err_q   <= err_d;
`ifdef TOPK_NAN_COUNT_EN
      nan_q     <= nan_d;
      out_nan_q <= out_nan_d;
`endif
    end
  end

  assign bus.s_ready = (state_q == ST_ACCUM);
  assign bus.m_valid = (state_q == ST_OUT);
  assign bus.m_err   = err_q;
`ifdef TOPK_NAN_COUNT_EN
  assign bus.m_nan_cnt = out_nan_q;
`endif

  // Flatten the latched list onto the result buses, best entry in the low bits.
  always_comb begin
    bus.m_val = '0;
    bus.m_idx = '0;
    for (int i = 0; i < K; i++) begin
      bus.m_val[i*DATA_WIDTH +: DATA_WIDTH] = out_q[i].val;
      bus.m_idx[i*IDX_W +: IDX_W]           = out_q[i].idx[IDX_W-1:0];
    end
  end

endmodule

// File: doc/topk_stream_dec.md
Name: topk_stream_dec

Overview:
- Streaming successor to the parallel argmax decision stage. Accepts one FP16 class score per beat over a valid/ready handshake.
- Keeps a sorted top-K list (value plus class index) across a frame of N_CLASSES beats.
- At end of frame, presents the K best classes, best first, on an output valid/ready handshake.
- Sits after the final dense layer, feeding the display/UART result path.

Parameters:
- DATA_WIDTH, 16, score width; the FP16 ordering rules below require 16.
- N_CLASSES, 10, beats per frame (≥2).
- K, 3, entries reported (1 ≤ K ≤ N_CLASSES).
- IDX_W, $clog2(N_CLASSES), derived class-index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  score beat valid
- s_ready  out  1  block can accept a beat
- s_data  in  DATA_WIDTH  FP16 score
- s_last  in  1  marks the final beat of a frame
- m_valid  out  1  result valid
- m_ready  in  1  consumer accepts result
- m_val  out  K×DATA_WIDTH  top-K scores; entry 0 is the largest
- m_idx  out  K×IDX_W  class indices matching m_val
- m_err  out  1  frame-length error for the presented frame

Behaviour:
- Reset (synchronous, rst high):
  - state=ACCUM, beat counter=0.
  - All list entries: val=16'hFC00 (−Inf), idx=0.
  - Outputs: s_ready=1, m_valid=0, m_err=0; m_val/m_idx read −Inf/0.
  - Reset mid-frame or mid-output discards everything; no result is produced.
- FP16 ordering:
  - NaN (exp=all-ones, mant≠0) is replaced by −Inf before comparison.
  - Sort key: sign=1 → invert all bits; sign=0 → invert the sign bit. Compare keys unsigned.
  - Consequently −0 < +0.
- ACCUM state:
  - s_ready=1. A beat is accepted on s_valid&&s_ready.
  - Accepted beat index = beat counter. Counter increments, saturating at N_CLASSES-1.
  - Single-cycle insertion: the new key is compared in parallel against all K entries.
  - Insertion position = first entry whose key is strictly less than the new key. Entries at and below that position shift down by one; the bottom entry drops out.
  - Ties keep the earlier index above the new beat.
  - If no entry is strictly less, the beat is discarded.
- Frame end:
  - The accepted beat with s_last=1 ends the frame.
  - m_err = (counter ≠ N_CLASSES-1) at that beat.
  - The final list, including that beat's insertion, is loaded into the output registers.
  - Next cycle: m_valid=1, state=OUT, s_ready=0.
  - Latency: last accepted beat edge → m_valid high one cycle later.
  - If the counter would exceed N_CLASSES-1 without s_last, the frame is forced to end at beat N_CLASSES-1 with m_err=1.
- OUT state:
  - m_val/m_idx/m_err stay stable while m_valid && !m_ready.
  - On m_valid&&m_ready: m_valid=0; list and counter reinitialise; state=ACCUM; s_ready=1 next cycle.
  - No input beat is accepted in the handoff cycle.
- If K > beats received (short frame), unfilled entries report −Inf/idx 0.

Optional Feature:
- Macro TOPK_NAN_COUNT_EN.
- Defined: adds output port m_nan_cnt, width $clog2(N_CLASSES+1).
  - Counts NaN beats accepted in the frame.
  - Latched with the result and held with m_val/m_idx.
  - Reset value 0.
- Undefined: port absent, no counter logic; NaN is still treated as −Inf.

Decomposition:
- Package cnn_dec_pkg holds:
  - FP16_NEG_INF=16'hFC00.
  - The fp16 sort-key function and the NaN-detect function.
  - A parameterised score/index pair typedef, shared with the existing argmax block.
- One sub-module: topk_insert. Combinational K-way compare plus shift-insert network, instantiated once and registered in the top.

Test Plan:
- Scores 0x3C00 (1.0) on idx 0..9 except idx7=0x4500 (5.0), idx2=0x4200 (3.0), idx5=0x4000 (2.0); K=3 → m_idx={7,2,5}, m_val={4500,4200,4000}, m_err=0, m_valid one cycle after the last beat.
- All beats equal 0x3800 → m_idx={0,1,2} (earliest wins ties).
- Negatives and signed zeros: idx0=0x8000 (−0), idx1=0x0000 (+0), rest 0xBC00 (−1.0) → m_idx={1,0,2}, m_val={0000,8000,BC00}.
- idx3=0x7E00 (NaN), rest 0xC000 (−2.0) → NaN never in top K, m_idx={0,1,2}; with TOPK_NAN_COUNT_EN m_nan_cnt=1.
- Hold m_ready=0 for 5 cycles with s_valid=1 → s_ready=0 throughout and outputs stable. Then m_ready=1 → the next frame's beat 0 is accepted two cycles later.
- s_last asserted on beat 6 → m_err=1, result over beats 0..6. Separately, rst asserted mid-frame at beat 4 → m_valid stays 0, and a following full frame gives a correct result.
